pipelined_shifter: RTL and testbench

Parametrised, pipelined N-bit barrel shifter for the ALU datapath. It supports logical left, logical right, arithmetic right and rotate-right operations. The block decomposes the shift into $clog2(N) binary-weighted stages and registers each one. It accepts one operation per cycle under a valid/ready handshake with full backpressure, replacing the single-cycle 32:1-mux shifters where the combinational path is too long.

---
 rtl/pipelined_shifter.sv | 90 +++++++++
 tb/tb_pipelined_shifter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined N-bit barrel shifter (SLL/SRL/SRA/ROR), one registered stage per shamt bit
// Single global advance enable gives full backpressure; out_valid/out_data come straight from the last stage flops.
module pipelined_shifter #(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    input  logic [$clog2(N)-1:0]   in_shamt,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data
);

    localparam int L = $clog2(N);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b11;

    logic           valid_q [L];
    logic [N-1:0]   data_q  [L];
    logic [1:0]     op_q    [L];
    logic [L-1:0]   shamt_q [L];

    logic           stage_valid [L];
    logic [N-1:0]   stage_data  [L];
    logic [1:0]     stage_op    [L];
    logic [L-1:0]   stage_shamt [L];
    logic [N-1:0]   stage_next  [L];

    logic adv;

    assign adv       = !valid_q[L-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];

    // Stage 0 is fed by the port, every later stage by its predecessor's register.
    always_comb begin
        stage_valid[0] = in_valid;
        stage_data[0]  = in_data;
        stage_op[0]    = in_op;
        stage_shamt[0] = in_shamt;
        for (int s = 1; s < L; s++) begin
            stage_valid[s] = valid_q[s-1];
            stage_data[s]  = data_q[s-1];
            stage_op[s]    = op_q[s-1];
            stage_shamt[s] = shamt_q[s-1];
        end
    end

    // Stage s shifts by 2**s; SRA keeps the sign because each stage's incoming MSB already is the sign.
    always_comb begin
        for (int s = 0; s < L; s++) begin
            stage_next[s] = stage_data[s];
            if (stage_shamt[s][s]) begin
                case (stage_op[s])
                    OP_SLL:  stage_next[s] = stage_data[s] << (1 << s);
                    OP_SRL:  stage_next[s] = stage_data[s] >> (1 << s);
                    OP_SRA:  stage_next[s] = $signed(stage_data[s]) >>> (1 << s);
                    default: stage_next[s] = (stage_data[s] >> (1 << s))
                                           | (stage_data[s] << (N - (1 << s)));
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < L; s++) begin
                valid_q[s] <= 1'b0;
                data_q[s]  <= '0;
                op_q[s]    <= '0;
                shamt_q[s] <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < L; s++) begin
                valid_q[s] <= stage_valid[s];
                data_q[s]  <= stage_next[s];
                op_q[s]    <= stage_op[s];
                shamt_q[s] <= stage_shamt[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - self-checking bench for pipelined_shifter (N=32 directed, N=8 randomised)
module tb_pipelined_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_data8;
    logic [2:0]  in_shamt8;
    logic [1:0]  in_op8;

    int checks = 0;
    int errors = 0;

    pipelined_shifter #(.N(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    pipelined_shifter #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .in_shamt(in_shamt8), .in_op(in_op8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
    );

    // Reference: shift of a w-bit value by k, computed arithmetically.
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int k,
                                              input logic [1:0] op, input int w);
        logic [31:0] mask, r;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        x = x & mask;
        case (op)
            2'b00: r = (x << k) & mask;
            2'b01: r = x >> k;
            2'b11: begin
                r = x >> k;
                if (x[w-1]) r = r | (mask & ~(mask >> k));
            end
            default: begin
                r = x;
                for (int i = 0; i < k; i++) r = (r >> 1) | ((r & 32'h1) << (w - 1));
            end
        endcase
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got %0b want 0", out_valid8); end
    endtask

    task automatic test_ops();
        logic [31:0] vd [5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h7FFF_FFF0};
        logic [4:0]  vs [5] = '{5'd31, 5'd31, 5'd31, 5'd1, 5'd4};
        logic [1:0]  vo [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] ve [5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h07FF_FFFF};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vd[i]; in_shamt = vs[i]; in_op = vo[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ops_in_ready[%0d] got %0b want 1", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #1;
            while (!out_valid && lat < 20) begin
                @(negedge clk); #1; lat++;
            end
            checks++; if (lat !== 5) begin errors++; $display("FAIL ops_latency[%0d] got %0d want 5", i, lat); end
            checks++; if (out_data !== ve[i]) begin errors++; $display("FAIL ops_data[%0d] got %h want %h", i, out_data, ve[i]); end
        end
    endtask

    task automatic test_zero_shift();
        int lat;
        out_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_shamt = 5'd0; in_op = 2'(op);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #1;
            while (!out_valid && lat < 20) begin
                @(negedge clk); #1; lat++;
            end
            checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency[op%0d] got %0d want 5", op, lat); end
            checks++; if (out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_data[op%0d] got %h want deadbeef", op, out_data); end
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_v;
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j < 8) begin
                in_valid = 1'b1; in_data = 32'hF000_0000; in_shamt = 5'(j); in_op = 2'b11;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_v = (j >= 5 && j <= 12);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid[c%0d] got %0b want %0b", j, out_valid, exp_v); end
            if (exp_v) begin
                exp_d = ref_shift(32'hF000_0000, j - 5, 2'b11, 32);
                checks++; if (out_data !== exp_d) begin errors++; $display("FAIL stream_data[c%0d] got %h want %h", j, out_data, exp_d); end
            end
            @(posedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] q [$];
        logic [31:0] held, exp_d;
        int got;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31)); in_op = 2'($urandom_range(0, 3));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready[%0d] got %0b want 1", i, in_ready); end
            q.push_back(ref_shift(in_data, int'(in_shamt), in_op, 32));
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        held = out_data;
        checks++; if (held !== q[0]) begin errors++; $display("FAIL bp_head got %h want %h", held, q[0]); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", k, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d] got %0b want 1", k, out_valid); end
            checks++; if (out_data !== held) begin errors++; $display("FAIL bp_data_hold[%0d] got %h want %h", k, out_data, held); end
        end
        got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_extra_result got %h want none", out_data);
                end else begin
                    exp_d = q.pop_front();
                    got++;
                    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bp_drain[%0d] got %h want %h", got, out_data, exp_d); end
                end
            end
            @(posedge clk);
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_count got %0d want 5", got); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'hFFFF_0000 + 32'(i); in_shamt = 5'(i + 1); in_op = 2'b00;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        in_data = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h want 00000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost[c%0d] got %0b want 0", c, out_valid); end
        end
    endtask

    task automatic test_random8();
        logic [7:0] q [$];
        logic [7:0] exp_d, prev_d;
        logic       prev_stall;
        int accepted, delivered, cycles;
        accepted = 0; delivered = 0; cycles = 0; prev_stall = 1'b0; prev_d = '0;
        while ((accepted < 1000 || q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            if (accepted < 1000) begin
                in_valid8  = ($urandom_range(0, 3) != 0);
                in_data8   = 8'($urandom);
                in_shamt8  = 3'($urandom_range(0, 7));
                in_op8     = 2'($urandom_range(0, 3));
                out_ready8 = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid8  = 1'b0;
                out_ready8 = 1'b1;
            end
            #1;
            if (prev_stall) begin
                checks++; if (out_valid8 !== 1'b1 || out_data8 !== prev_d) begin
                    errors++; $display("FAIL rnd_stall_hold got v%0b %h want v1 %h", out_valid8, out_data8, prev_d);
                end
            end
            checks++; if (in_ready8 !== (!out_valid8 || out_ready8)) begin
                errors++; $display("FAIL rnd_in_ready got %0b want %0b", in_ready8, (!out_valid8 || out_ready8));
            end
            if (out_valid8 && out_ready8) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_extra_result got %h want none", out_data8);
                end else begin
                    exp_d = q.pop_front();
                    delivered++;
                    checks++; if (out_data8 !== exp_d) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", delivered, out_data8, exp_d); end
                end
            end
            if (in_valid8 && in_ready8) begin
                q.push_back(8'(ref_shift({24'h0, in_data8}, int'(in_shamt8), in_op8, 8)));
                accepted++;
            end
            prev_stall = out_valid8 && !out_ready8;
            prev_d = out_data8;
            @(posedge clk);
            cycles++;
        end
        in_valid8 = 1'b0;
        checks++; if (accepted !== 1000) begin errors++; $display("FAIL rnd_accepted got %0d want 1000", accepted); end
        checks++; if (delivered !== accepted) begin errors++; $display("FAIL rnd_delivered got %0d want %0d", delivered, accepted); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
        test_reset();
        test_ops();
        test_zero_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
